// File: rtl/period_meter.sv
// -----------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow, asynchronous input waveform in
// units of clk. sig_in is synchronised through two flops; a third flop keeps
// the previous synchronised value so a rising edge can be detected. The period
// counter runs from one rising edge to the next. On every rising edge after the
// first, the results are published with a one-cycle period_valid strobe. If no
// rising edge arrives within 2^W-1 cycles, the sticky timeout flag is set and
// the block re-arms.
//
// Optional build macro:
//   PERIOD_METER_DUTY_EN  defined   : high-time counter present, high_cycles valid
//                         undefined : high-time logic omitted, high_cycles = 0
//
// Ports:
//   clk          in   system clock, all logic on posedge
//   rst          in   asynchronous active-low reset
//   en           in   measurement enable (synchronous to clk)
//   sig_in       in   signal under measurement (asynchronous to clk)
//   period       out  [W-1:0] last measured period in clk cycles
//   high_cycles  out  [W-1:0] clk cycles sig_in was high in that period
//   period_valid out  one-cycle strobe when period/high_cycles update
//   timeout      out  sticky: no rising edge within 2^W-1 cycles
//   busy         out  high while a measurement is in progress
// -----------------------------------------------------------------------------
module period_meter #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         sig_in,
    output logic [W-1:0] period,
    output logic [W-1:0] high_cycles,
    output logic         period_valid,
    output logic         timeout,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] ONE     = W'(1);

    state_t         state, state_next;
    logic           s1, s2, s3;
    logic           rise;
    logic [W-1:0]   cnt, cnt_next;
    logic [W-1:0]   period_next;
    logic           valid_next;
    logic           timeout_next;

    // Two-flop synchroniser plus one history flop for edge detection. The
    // fixed two-cycle latency shifts every edge equally, so it cancels out of
    // both the period and the high time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking, so each stage takes the previous stage's old
            // value; blocking here would collapse the chain into a single flop.
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign busy = (state == MEASURE);

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case can leave a latch behind.
        state_next   = state;
        cnt_next     = cnt;
        period_next  = period;
        valid_next   = 1'b0;
        timeout_next = timeout;

        if (!en) begin
            state_next   = IDLE;
            cnt_next     = '0;
            timeout_next = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A rise coinciding with en is deliberately ignored.
                    cnt_next   = '0;
                    state_next = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_next   = ONE;
                        state_next = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_next  = cnt;
                        valid_next   = 1'b1;
                        timeout_next = 1'b0;
                        cnt_next     = ONE;
                    end else if (cnt == CNT_MAX) begin
                        // Limit check comes before the increment: cnt never wraps.
                        timeout_next = 1'b1;
                        cnt_next     = '0;
                        state_next   = ARM;
                    end else begin
                        cnt_next = cnt + ONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            period       <= period_next;
            period_valid <= valid_next;
            timeout      <= timeout_next;
        end
    end

`ifdef PERIOD_METER_DUTY_EN
    logic [W-1:0] hcnt, hcnt_next, high_next;

    // High-time counter follows cnt's control flow; it only advances while
    // the synchronised input is high, so it can never exceed cnt.
    always_comb begin
        hcnt_next = hcnt;
        high_next = high_cycles;
        if (!en || state == IDLE) begin
            hcnt_next = '0;
        end else if (state == ARM) begin
            if (rise) hcnt_next = ONE;
        end else if (state == MEASURE) begin
            if (rise) begin
                high_next = hcnt;
                hcnt_next = ONE;
            end else if (cnt == CNT_MAX) begin
                hcnt_next = '0;
            end else if (s2) begin
                hcnt_next = hcnt + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt        <= '0;
            high_cycles <= '0;
        end else begin
            hcnt        <= hcnt_next;
            high_cycles <= high_next;
        end
    end
`else
    assign high_cycles = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// -----------------------------------------------------------------------------
// tb_period_meter
//
// Directed bench for period_meter built with W=8. Each scenario task drives
// sig_in cycle by cycle and compares results against hand-computed values.
// A negedge monitor records every period_valid strobe into a queue that the
// scenario tasks inspect. Expected high_cycles collapse to 0 when the design
// is built without PERIOD_METER_DUTY_EN.
// -----------------------------------------------------------------------------
module tb_period_meter;

    localparam int W = 8;

`ifdef PERIOD_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] p;
        logic [W-1:0] h;
    } strobe_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period;
    logic [W-1:0] high_cycles;
    logic         period_valid;
    logic         timeout;
    logic         busy;

    int      tests_run    = 0;
    int      tests_failed = 0;
    strobe_t sq[$];

    period_meter #(.W(W)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .en           (en),
        .sig_in       (sig_in),
        .period       (period),
        .high_cycles  (high_cycles),
        .period_valid (period_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            strobe_t s;
            s.p = period;
            s.h = high_cycles;
            sq.push_back(s);
        end
    end

    function automatic logic [W-1:0] exp_high(input int h);
        return DUTY ? W'(h) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = v;
            tick();
        end
    endtask

    task automatic square(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        drive(1'b0, 3);
        en = 1'b1;
        drive(1'b0, 3);
        sq.delete();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        en     = 1'b1;
        sig_in = 1'b0;
        #12;
        tests_run++;
        if ({period, high_cycles, period_valid, timeout, busy} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%b t=%b b=%b, want all 0",
                     period, high_cycles, period_valid, timeout, busy);
        end
    endtask

    task automatic test_square();
        int ep[3] = '{10, 10, 10};
        int eh[3] = '{5, 5, 5};
        @(posedge clk);
        #1 rst_n = 1'b1;
        sq.delete();
        drive(1'b0, 2);
        square(5, 5, 3);
        drive(1'b1, 6);
        tests_run++;
        if (sq.size() !== 3) begin
            tests_failed++;
            $display("FAIL square_count: got %0d strobes, want 3", sq.size());
        end
        for (int i = 0; i < 3 && i < sq.size(); i++) begin
            tests_run++;
            if (sq[i].p !== W'(ep[i]) || sq[i].h !== exp_high(eh[i])) begin
                tests_failed++;
                $display("FAIL square_strobe%0d: got %0d/%0d, want %0d/%0d",
                         i, sq[i].p, sq[i].h, ep[i], exp_high(eh[i]));
            end
        end
        tests_run++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL square_flags: got busy=%b timeout=%b, want 1/0", busy, timeout);
        end
    endtask

    task automatic test_period_change();
        int ep[6] = '{7, 7, 7, 3, 4, 4};
        int eh[6] = '{2, 2, 2, 2, 3, 3};
        restart();
        square(2, 5, 3);
        drive(1'b1, 2);
        drive(1'b0, 1);
        square(3, 1, 2);
        drive(1'b1, 6);
        tests_run++;
        if (sq.size() !== 6) begin
            tests_failed++;
            $display("FAIL change_count: got %0d strobes, want 6", sq.size());
        end
        for (int i = 0; i < 6 && i < sq.size(); i++) begin
            tests_run++;
            if (sq[i].p !== W'(ep[i]) || sq[i].h !== exp_high(eh[i])) begin
                tests_failed++;
                $display("FAIL change_strobe%0d: got %0d/%0d, want %0d/%0d",
                         i, sq[i].p, sq[i].h, ep[i], exp_high(eh[i]));
            end
        end
    endtask

    task automatic test_timeout();
        restart();
        // Rise is captured 3 edges after sig_in goes high; the limit is
        // reached 255 edges later, i.e. 258 edges after the drive.
        drive(1'b1, 2);
        drive(1'b0, 248);
        tests_run++;
        if (timeout !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: got timeout=%b busy=%b, want 0/1", timeout, busy);
        end
        drive(1'b0, 10);
        tests_run++;
        if (timeout !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_set: got timeout=%b busy=%b, want 1/0", timeout, busy);
        end
        tests_run++;
        if (sq.size() !== 0 || period !== W'(4)) begin
            tests_failed++;
            $display("FAIL timeout_hold: got %0d strobes period=%0d, want 0 strobes period=4",
                     sq.size(), period);
        end
        drive(1'b1, 10);
        drive(1'b0, 10);
        drive(1'b1, 6);
        tests_run++;
        if (sq.size() !== 1) begin
            tests_failed++;
            $display("FAIL rearm_count: got %0d strobes, want 1", sq.size());
        end else begin
            tests_run++;
            if (sq[0].p !== W'(20) || sq[0].h !== exp_high(10)) begin
                tests_failed++;
                $display("FAIL rearm_strobe: got %0d/%0d, want 20/%0d",
                         sq[0].p, sq[0].h, exp_high(10));
            end
        end
        tests_run++;
        if (timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_clear: got %b, want 0", timeout);
        end
    endtask

    task automatic test_en_drop();
        restart();
        square(6, 6, 2);
        drive(1'b1, 6);
        drive(1'b0, 2);
        en = 1'b0;
        drive(1'b0, 1);
        tests_run++;
        if (period !== W'(12) || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL endrop_hold: got period=%0d busy=%b, want 12/0", period, busy);
        end
        en = 1'b1;
        drive(1'b0, 3);
        square(6, 6, 2);
        drive(1'b1, 6);
        // Strobes: two before the drop, none for the interrupted period,
        // none for the arming rise, then two full periods.
        tests_run++;
        if (sq.size() !== 4) begin
            tests_failed++;
            $display("FAIL endrop_count: got %0d strobes, want 4", sq.size());
        end
        for (int i = 0; i < 4 && i < sq.size(); i++) begin
            tests_run++;
            if (sq[i].p !== W'(12) || sq[i].h !== exp_high(6)) begin
                tests_failed++;
                $display("FAIL endrop_strobe%0d: got %0d/%0d, want 12/%0d",
                         i, sq[i].p, sq[i].h, exp_high(6));
            end
        end
    endtask

    task automatic test_async_reset();
        restart();
        square(5, 5, 2);
        drive(1'b1, 2);
        @(posedge clk);
        #3;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        #1;
        tests_run++;
        if ({period, high_cycles, period_valid, timeout, busy} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got p=%0d h=%0d v=%b t=%b b=%b, want all 0",
                     period, high_cycles, period_valid, timeout, busy);
        end
        sq.delete();
        drive(1'b0, 2);
        rst_n = 1'b1;
        drive(1'b0, 3);
        tests_run++;
        if (sq.size() !== 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got %0d strobes busy=%b, want 0/0", sq.size(), busy);
        end
        square(5, 5, 2);
        drive(1'b1, 6);
        tests_run++;
        if (sq.size() !== 2) begin
            tests_failed++;
            $display("FAIL post_reset_count: got %0d strobes, want 2", sq.size());
        end
        for (int i = 0; i < 2 && i < sq.size(); i++) begin
            tests_run++;
            if (sq[i].p !== W'(10) || sq[i].h !== exp_high(5)) begin
                tests_failed++;
                $display("FAIL post_reset_strobe%0d: got %0d/%0d, want 10/%0d",
                         i, sq[i].p, sq[i].h, exp_high(5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_period_change();
        test_timeout();
        test_en_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
